freq_counter: RTL and testbench
===============================

// Module: freq_counter
// PURPOSE
//  Gated pulse counter for the frequency meter. Counts rising edges of an asynchronous
//  input over a fixed gate window and latches the count as a binary frequency in Hz.
//  Sits directly upstream of the BCD/7-segment display stage, which takes freq_out
//  and expands it to 6 decimal digits (0..999999).
// PARAMETERS
//  CLK_FREQ   50_000_000  system clock in Hz; 1 s gate = CLK_FREQ cycles
//  N          20          width of freq_out; must satisfy 2^N > MAX_COUNT
//  MAX_COUNT  999_999     saturation value (6-digit display limit)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst_n      in   1  asynchronous active-low reset
//  en         in   1  measurement enable (synchronous, level)
//  signal_in  in   1  measured signal, asynchronous to clk
//  freq_out   out  N  last latched frequency, Hz, binary; feeds the display stage
//  valid      out  1  one-cycle pulse when freq_out/overflow update
//  overflow   out  1  last window exceeded MAX_COUNT (freq_out == MAX_COUNT)
//  gate_led   out  1  high during the first half of each gate window (heartbeat)
// BEHAVIOUR
//  - Reset (async assert, sync deassert handled externally): freq_out=0, valid=0,
//    overflow=0, gate_led=0, FSM=IDLE, all counters and sync flops = 0.
//  - signal_in: 2-FF synchronizer + 1 edge flop; edge = s2 & ~s3. Latency of 3 clk
//    from the input transition to edge. Max countable frequency is CLK_FREQ/2.
//  - FSM, 2 states:
//    IDLE:    gate_cnt=0, acc=0; outputs hold their last values. en=1 -> MEASURE.
//    MEASURE: gate_cnt counts 0..GATE-1 (GATE=CLK_FREQ). acc += edge and saturates at
//             MAX_COUNT. On the terminal cycle (gate_cnt==GATE-1): freq_out<=acc+edge
//             (saturated), overflow<=(acc+edge>MAX_COUNT), valid=1 on the next cycle
//             only, gate_cnt<=0, acc<=0. An edge on the terminal cycle belongs to the
//             closing window.
//             en=0 -> IDLE immediately; the partial window is discarded with no valid pulse.
//  - The first window after reset or after en rises is a full GATE cycles long.
//  - acc width is N+1 so saturation compare never wraps; freq_out never exceeds MAX_COUNT.
//  - gate_led = (gate_cnt < GATE/2) in MEASURE, 0 in IDLE.
//  - rst_n asserted mid-window: everything is cleared at once, no valid pulse.
// CONFIGURATION
//  FREQ_COUNTER_GATE_SEL_EN defined: adds input gate_sel (1 bit). gate_sel=0 selects a
//   1 s gate; gate_sel=1 selects a 100 ms gate (GATE=CLK_FREQ/10), and the latched value
//   is acc*10 ((acc<<3)+(acc<<1)), then saturated to MAX_COUNT with overflow set if
//   clipped. gate_sel is sampled only at window start; a change mid-window takes effect
//   at the next window.
//  Not defined: no gate_sel port; the gate is fixed at 1 s and no scaling logic is built.
// STRUCTURE
//  - Shared package freq_pkg: state typedef {IDLE, MEASURE}, GATE_1S/GATE_100MS
//    derivation functions, DISP_MAX=999_999, clog2 helper for gate_cnt width.
//  - Sub-module sync_edge_det (clk, rst_n, d_async -> rise pulse): 3-flop synchronizer
//    and edge detector, reused by other asynchronous inputs of the meter.
//  - Top holds the FSM, gate counter, saturating accumulator and output registers.
// TESTING (sim with CLK_FREQ=1000, so GATE=1000 cycles)
//  1 en=1, square wave with period 10 clk -> valid after 1st window, freq_out=100,
//    overflow=0; every later window gives 100, with valid spaced exactly 1000 cycles.
//  2 signal_in held low, en=1 -> freq_out=0, valid still pulses every 1000 cycles.
//  3 Override MAX_COUNT=50, period 10 clk (100 edges) -> freq_out=50, overflow=1;
//    next window at period 40 (25 edges) -> freq_out=25, overflow=0.
//  4 en dropped at gate_cnt=500 -> no valid, freq_out holds its old value; en back
//    high -> next valid exactly 1000+1 cycles later with a full-window count.
//  5 rst_n pulsed low mid-window -> all outputs 0 asynchronously; on release counting
//    restarts from 0 with no spurious edge counted (input held high during reset).
//  6 FREQ_COUNTER_GATE_SEL_EN, gate_sel=1, period 10 clk -> windows of 100 cycles,
//    freq_out=100 (10 edges*10); toggle gate_sel mid-window -> it applies next window.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and constant helpers for the frequency meter:
// FSM state type, gate-length derivation and display limit.
package freq_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int DISP_MAX = 999_999;

  function automatic int gate_1s(input int clk_freq);
    return clk_freq;
  endfunction

  function automatic int gate_100ms(input int clk_freq);
    return clk_freq / 10;
  endfunction

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < 32'(value)) begin
        r = i + 1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer with rising-edge detect for asynchronous meter inputs.
// rise follows a d_async rising transition by three clk edges.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d_async,
  output logic rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_arm;

  // r_arm masks the detector until r_s3 holds a real sample, so an input already high at reset release is not seen as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_s3  <= 1'b0;
      r_arm <= 2'd0;
    end else begin
      r_s1 <= d_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_arm != 2'd3) begin
        r_arm <= r_arm + 2'd1;
      end else begin
        r_arm <= r_arm;
      end
    end
  end

  assign rise = r_s2 & ~r_s3 & (r_arm == 2'd3);

endmodule

// File: rtl/freq_counter.sv
// Gated pulse counter: counts signal_in rising edges per gate window and latches the result.
// Optional macro FREQ_COUNTER_GATE_SEL_EN adds gate_sel (100 ms gate, result scaled x10).
module freq_counter
  import freq_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int N         = 20,
  parameter int MAX_COUNT = DISP_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         signal_in,
`ifdef FREQ_COUNTER_GATE_SEL_EN
  input  logic         gate_sel,
`endif
  output logic [N-1:0] freq_out,
  output logic         valid,
  output logic         overflow,
  output logic         gate_led
);

  localparam int GATE_L = gate_1s(CLK_FREQ);
  localparam int GW     = (clog2_f(GATE_L) < 1) ? 1 : clog2_f(GATE_L);
  localparam int AW     = N + 1;
  localparam int SW     = AW + 4;
  localparam logic [GW-1:0] TERM_L  = GW'(GATE_L - 1);
  localparam logic [GW-1:0] HALF_L  = GW'(GATE_L / 2);
  // One count above MAX_COUNT is kept so a clipped window still reads as overflow
  localparam logic [AW-1:0] ACC_CAP = AW'(MAX_COUNT + 1);
  localparam logic [SW-1:0] MAX_S   = SW'(MAX_COUNT);
`ifdef FREQ_COUNTER_GATE_SEL_EN
  localparam int GATE_S = gate_100ms(CLK_FREQ);
  localparam logic [GW-1:0] TERM_S = GW'(GATE_S - 1);
  localparam logic [GW-1:0] HALF_S = GW'(GATE_S / 2);
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gate_cnt;
  logic [GW-1:0] w_gate_nxt;
  logic [GW-1:0] w_term;
  logic [GW-1:0] w_half_nxt;
  logic [AW-1:0] r_acc;
  logic [AW-1:0] w_acc_nxt;
  logic [AW-1:0] w_sum;
  logic [AW-1:0] w_sum_cap;
  logic [SW-1:0] w_val;
  logic [N-1:0]  r_freq;
  logic [N-1:0]  w_freq;
  logic          r_valid;
  logic          r_ovf;
  logic          r_led;
  logic          w_ovf;
  logic          w_latch;
  logic          w_led_nxt;
  logic          w_edge;

  sync_edge_det u_sync_edge_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_async (signal_in),
    .rise    (w_edge)
  );

  assign w_sum     = r_acc + {{N{1'b0}}, w_edge};
  assign w_sum_cap = (w_sum > ACC_CAP) ? ACC_CAP : w_sum;

`ifdef FREQ_COUNTER_GATE_SEL_EN
  logic          r_sel;
  logic          w_sel_nxt;
  logic [SW-1:0] w_ext;

  // Gate length is chosen only when a window opens
  always_comb begin
    w_sel_nxt = r_sel;
    if ((r_state == IDLE) || w_latch) begin
      w_sel_nxt = gate_sel;
    end else begin
      w_sel_nxt = r_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= 1'b0;
    end else begin
      r_sel <= w_sel_nxt;
    end
  end

  assign w_term     = r_sel ? TERM_S : TERM_L;
  assign w_half_nxt = w_sel_nxt ? HALF_S : HALF_L;
  assign w_ext      = {4'b0000, w_sum_cap};
  assign w_val      = r_sel ? ((w_ext << 3) + (w_ext << 1)) : w_ext;
`else
  assign w_term     = TERM_L;
  assign w_half_nxt = HALF_L;
  assign w_val      = {4'b0000, w_sum_cap};
`endif

  assign w_ovf     = (w_val > MAX_S);
  assign w_freq    = w_ovf ? MAX_S[N-1:0] : w_val[N-1:0];
  assign w_led_nxt = (w_state_nxt == MEASURE) && (w_gate_nxt < w_half_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_gate_nxt  = r_gate_cnt;
    w_acc_nxt   = r_acc;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        w_gate_nxt = '0;
        w_acc_nxt  = '0;
        if (en) begin
          w_state_nxt = MEASURE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEASURE: begin
        if (!en) begin
          w_state_nxt = IDLE;
          w_gate_nxt  = '0;
          w_acc_nxt   = '0;
        end else if (r_gate_cnt == w_term) begin
          w_latch    = 1'b1;
          w_gate_nxt = '0;
          w_acc_nxt  = '0;
        end else begin
          w_gate_nxt = r_gate_cnt + {{(GW-1){1'b0}}, 1'b1};
          w_acc_nxt  = w_sum_cap;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gate_nxt  = '0;
        w_acc_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_gate_cnt <= '0;
      r_acc      <= '0;
      r_freq     <= '0;
      r_valid    <= 1'b0;
      r_ovf      <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gate_cnt <= w_gate_nxt;
      r_acc      <= w_acc_nxt;
      r_valid    <= w_latch;
      r_led      <= w_led_nxt;
      if (w_latch) begin
        r_freq <= w_freq;
        r_ovf  <= w_ovf;
      end else begin
        r_freq <= r_freq;
        r_ovf  <= r_ovf;
      end
    end
  end

  assign freq_out = r_freq;
  assign valid    = r_valid;
  assign overflow = r_ovf;
  assign gate_led = r_led;

endmodule

// File: tb/tb_freq_counter.sv
// Scoreboard bench for freq_counter at CLK_FREQ=1000: a default instance and one saturating at 50.
// Windows whose content straddles a stimulus change are queued with cnt=-1 (value not compared).
`timescale 1ns/1ps
module tb_freq_counter;
  import freq_pkg::*;

  localparam int CLK_FREQ = 1000;
  localparam int N        = 20;
  localparam int SAT_MAX  = 50;
  localparam int GATE     = 1000;

  typedef struct {
    int cnt;
    int gap;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         signal_in;
`ifdef FREQ_COUNTER_GATE_SEL_EN
  logic         gate_sel;
`endif
  logic [N-1:0] freq_out;
  logic [N-1:0] freq_sat;
  logic         valid;
  logic         valid_sat;
  logic         ovf;
  logic         ovf_sat;
  logic         led;
  logic         led_sat;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   ref_cyc  = 0;
  int   n_valid  = 0;
  int   gen_half = 0;
  logic gen_level = 1'b0;

  freq_counter #(.CLK_FREQ(CLK_FREQ), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .signal_in(signal_in),
`ifdef FREQ_COUNTER_GATE_SEL_EN
    .gate_sel(gate_sel),
`endif
    .freq_out(freq_out), .valid(valid), .overflow(ovf), .gate_led(led)
  );

  freq_counter #(.CLK_FREQ(CLK_FREQ), .N(N), .MAX_COUNT(SAT_MAX)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .signal_in(signal_in),
`ifdef FREQ_COUNTER_GATE_SEL_EN
    .gate_sel(gate_sel),
`endif
    .freq_out(freq_sat), .valid(valid_sat), .overflow(ovf_sat), .gate_led(led_sat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int cnt, input int gap);
    exp_t e;
    e.cnt = cnt;
    e.gap = gap;
    sb_q.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("drain_timeout", sb_q.size(), 0);
  endtask

  // Square-wave / level generator for signal_in
  initial begin
    int gcnt;
    gcnt = 0;
    signal_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_half == 0) begin
        signal_in = gen_level;
        gcnt = 0;
      end else begin
        gcnt++;
        if (gcnt >= gen_half) begin
          gcnt = 0;
          signal_in = ~signal_in;
        end
      end
    end
  end

  // Output monitor: pops one expectation per valid pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        n_valid++;
        check("valid_pair", valid_sat, 1'b1);
        if (sb_q.size() == 0) begin
          check("valid_without_expect", valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          if (e.gap != 0) check("valid_gap", cyc - ref_cyc, e.gap);
          if (e.cnt >= 0) begin
            check("freq_out", freq_out, (e.cnt > DISP_MAX) ? DISP_MAX : e.cnt);
            check("overflow", ovf, (e.cnt > DISP_MAX));
            check("freq_sat", freq_sat, (e.cnt > SAT_MAX) ? SAT_MAX : e.cnt);
            check("ovf_sat", ovf_sat, (e.cnt > SAT_MAX));
          end
          check("led_window_start", led, 1'b1);
        end
        ref_cyc = cyc;
      end
    end
  end

  initial begin
    int nv;
    rst_n = 1'b0;
    en    = 1'b0;
`ifdef FREQ_COUNTER_GATE_SEL_EN
    gate_sel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_freq", freq_out, 0);
    check("rst_valid", valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_led", led, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    gen_half = 5;
    repeat (20) @(negedge clk);

    // period 10 -> 100 per window, valid every 1000 cycles
    push(100, GATE + 1); push(100, GATE); push(100, GATE);
    en = 1'b1;
    ref_cyc = cyc;
    wait_drain(4000);

    // input held low -> 0, valid still pulses
    gen_half = 0; gen_level = 1'b0;
    push(-1, GATE); push(0, GATE); push(0, GATE);
    wait_drain(4000);
    repeat (600) @(negedge clk);
    check("led_second_half", led, 1'b0);
    check("freq_zero", freq_out, 0);

    // saturation on dut_sat, then period 40 -> 25
    gen_half = 5;
    push(-1, GATE); push(100, GATE);
    wait_drain(3000);
    gen_half = 20;
    push(-1, GATE); push(25, GATE);
    wait_drain(3000);

    // en dropped mid-window
    gen_half = 5;
    push(-1, GATE); push(100, GATE);
    wait_drain(3000);
    repeat (500) @(negedge clk);
    en = 1'b0;
    nv = n_valid;
    repeat (1500) @(negedge clk);
    check("no_valid_idle", n_valid, nv);
    check("freq_hold", freq_out, 100);
    check("led_idle", led, 1'b0);
    push(100, GATE + 1);
    en = 1'b1;
    ref_cyc = cyc;
    wait_drain(3000);

    // async reset mid-window with input held high
    repeat (300) @(negedge clk);
    check("led_first_half", led, 1'b1);
    gen_half = 0; gen_level = 1'b1;
    rst_n = 1'b0;
    #1;
    check("midrst_freq", freq_out, 0);
    check("midrst_valid", valid, 0);
    check("midrst_ovf", ovf_sat, 0);
    check("midrst_led", led, 0);
    check("midrst_freq_sat", freq_sat, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    push(0, GATE + 1);
    ref_cyc = cyc;
    wait_drain(3000);
    gen_half = 5;
    push(-1, GATE); push(100, GATE);
    wait_drain(3000);

`ifdef FREQ_COUNTER_GATE_SEL_EN
    // gate_sel changes apply at the next window
    gate_sel = 1'b1;
    push(100, GATE); push(100, GATE / 10); push(100, GATE / 10);
    wait_drain(3000);
    repeat (50) @(negedge clk);
    gate_sel = 1'b0;
    push(100, GATE / 10); push(100, GATE);
    wait_drain(3000);
`endif

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
